// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// merge_bytes works on a fixed maximum width; callers extend into it and truncate back out.
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int MERGE_MAX_W  = 256;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  // Per byte lane: take new_w where be is set, otherwise keep old_w.
  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int k = 0; k < MERGE_MAX_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Memory-clear sequencer: after reset, walks every address once writing zero,
// then parks in READY until the next reset.
module ram_clear_ctrl
  import dp_ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output clr_state_e        state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    if (state_q == CLEAR) begin
      // A reset cycle restarts the walk, so it must not write anything itself.
      clr_we_o = ~rst_i;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;
  assign state_o    = state_q;

endmodule

// File: rtl/dp_ram_be.sv
// Simple dual-port RAM with byte-enable writes, optional output register,
// selectable read-during-write behaviour and a reset-started clear sequence.
module dp_ram_be
  import dp_ram_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               collision,
  output logic               busy
);

  localparam int              AW1       = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = AW1'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_e        clr_state;

  ram_clear_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clk_i     (clk),
    .rst_i     (rst),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .state_o   (clr_state)
  );

  logic user_ok;
  logic wr_in_range, rd_in_range;
  logic wr_fire, rd_fire, rd_collide;
  logic [WIDTH-1:0] wr_merged;

  assign user_ok     = (clr_state == READY) && !rst;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
  assign wr_fire     = user_ok && wr_en && wr_in_range;
  assign rd_fire     = user_ok && rd_en;
  assign rd_collide  = wr_fire && (wr_addr == rd_addr);

  // The merged word is both what gets stored and what a bypassed read returns.
  assign wr_merged = WIDTH'(merge_bytes(MERGE_MAX_W'(mem_q[wr_addr]),
                                        MERGE_MAX_W'(wr_data),
                                        MERGE_MAX_BE'(wr_be)));

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_coll_q, s1_coll_d;

  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = rd_fire;
    s1_coll_d  = rd_fire && rd_collide;
    if (rd_fire) begin
      if (!rd_in_range)                    s1_data_d = '0;
      else if (rd_collide && BYPASS != 0)  s1_data_d = wr_merged;
      else                                 s1_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_coll_q  <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      s1_coll_q  <= s1_coll_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] s2_data_q, s2_data_d;
      logic             s2_valid_q, s2_coll_q;

      assign s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
          s2_coll_q  <= 1'b0;
        end else begin
          s2_data_q  <= s2_data_d;
          s2_valid_q <= s1_valid_q;
          s2_coll_q  <= s1_coll_q;
        end
      end

      assign rd_data   = s2_data_q;
      assign rd_valid  = s2_valid_q;
      assign collision = s2_coll_q;
    end else begin : g_no_out_reg
      assign rd_data   = s1_data_q;
      assign rd_valid  = s1_valid_q;
      assign collision = s1_coll_q;
    end
  endgenerate

endmodule

// File: doc/dp_ram_be.md
Name: dp_ram_be

Overview:
Parametrised simple dual-port RAM (one write port, one read port, shared clock). It is the successor to the team's fixed 16x8 RAM. Write and read run concurrently in the same cycle instead of write taking priority. It adds byte-enable writes, an optional output register, a selectable read-during-write policy, and a hardware memory-clear sequencer started by reset. It serves as the generic storage primitive for FIFOs, buffers and register files elsewhere in the design.

Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; any value >= 2.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- BYPASS, 1, same-address read/write in one cycle: 1 = read returns new (merged) data; 0 = read returns old data.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset; also starts the memory clear.
- wr_en, input, 1, write request.
- wr_addr, input, ADDR_W, write address.
- wr_be, input, WIDTH/8, byte enables; bit k enables byte [8k+7:8k].
- wr_data, input, WIDTH, write data.
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_W, read address.
- rd_data, output, WIDTH, read data; holds its value between reads.
- rd_valid, output, 1, one-cycle pulse aligned with new rd_data.
- collision, output, 1, pulse aligned with rd_valid; the read hit the address written in its issue cycle.
- busy, output, 1, high while the clear sequence runs.

Behaviour:
- Reset and clear:
  - Any cycle with rst=1: FSM goes to CLEAR, clear counter = 0, busy=1.
  - Outputs forced: rd_data=0, rd_valid=0, collision=0. Output pipeline stage is also zeroed.
  - FSM states are CLEAR and READY.
- CLEAR (rst=0):
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - On the cycle writing DEPTH-1, transitions to READY. busy falls on the following edge.
  - The clear takes exactly DEPTH cycles after rst deasserts.
- Reset mid-clear: counter returns to 0 and the clear restarts from the beginning.
- In CLEAR, user wr_en and rd_en are ignored: no memory change, no rd_valid.
- Write (READY): on an edge with wr_en=1 and wr_addr < DEPTH, each byte with wr_be[k]=1 is updated; other bytes keep their value. wr_be=0 gives no change.
- Read (READY):
  - rd_en=1 at edge N gives rd_valid=1 with rd_data=mem[rd_addr] after edge N+1+OUT_REG.
  - Back-to-back reads produce a result every cycle (full throughput).
- Out-of-range addresses (addr >= DEPTH, only possible when DEPTH is not a power of 2):
  - Writes are dropped.
  - Reads return 0 with rd_valid=1.
  - No wrap-around.
- Read and write in the same cycle:
  - Different addresses: fully independent.
  - Same address, BYPASS=1: rd_data = per byte, wr_data where wr_be=1, else the old value.
  - Same address, BYPASS=0: rd_data = old word.
  - In both cases collision=1, aligned with that rd_valid.
- No read: rd_valid=0, collision=0, rd_data unchanged.

Decomposition:
- Shared package dp_ram_pkg holds:
  - the state enum {CLEAR, READY};
  - a byte-merge function (old, new, be) -> merged word, reused for writes and for bypass.
- One natural sub-module: ram_clear_ctrl.
  - Contains the FSM and clear counter.
  - Outputs busy, clr_we and clr_addr; these are muxed onto the write port ahead of user writes.
- Storage array and read pipeline stay in dp_ram_be.

Test Plan:
- Reset clear (DEPTH=16, OUT_REG=0): preload all words with 0xA5, pulse rst 1 cycle -> busy=1 for exactly 16 cycles; reading addresses 0..15 then returns 0x00 each, rd_valid one cycle after each rd_en.
- Concurrent write and read, different addresses: write 0x3C to addr 3 while reading addr 7 (holding 0x11) -> rd_data=0x11, collision=0; next cycle read addr 3 -> 0x3C.
- Byte enables (WIDTH=32): mem[5]=0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> read returns 0x11BB33DD.
- Collision: mem[2]=0x0000, write 0xFFFF (be=2'b01) and read addr 2 same cycle -> BYPASS=1 returns 0x00FF; BYPASS=0 returns 0x0000; collision=1 in both cases.
- Latency (OUT_REG=1): rd_en on 4 consecutive cycles at addrs 0..3 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en, data in order.
- Reset mid-clear: assert rst at clear cycle 8 -> busy stays high, 16 more cycles after rst drops; wr_en/rd_en during busy cause no write and no rd_valid.
